rle_decompressor: RTL and testbench

//  Parametrised successor to the ifmap decompressor. Fetches compressed beats from memory through
//  a req/valid/ack handshake and expands them to element packets for the PE-array input FIFO.
//  Two modes, selected per layer:
//  - RLE: zero-run tokens, for sparse CONV ifmaps.
//  - RAW: pass-through, for dense FC data.

---
 rtl/rle_decompressor.sv | 174 +++++++++++++++++
 tb/tb_rle_decompressor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rle_decompressor.sv
// RLE / RAW ifmap decompressor: fetches beats over req/valid/ack and packs elements into packets.
// Optional DECOMP_STATS_EN adds zero-element and output-stall counters.
module rle_decompressor #(
    parameter int BEAT_BYTES = 8,
    parameter int DATA_W     = 8,
    parameter int RUN_W      = 8,
    parameter int PKT_ELEMS  = 4,
    parameter int CNT_W      = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          rle_mode,
    input  logic [CNT_W-1:0]              total_elems,
    output logic                          mem_req,
    input  logic [BEAT_BYTES*8-1:0]       mem_data,
    input  logic                          mem_data_valid,
    output logic                          mem_ack,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [PKT_ELEMS*DATA_W-1:0]   pkt_data,
    output logic                          pkt_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err_overrun
`ifdef DECOMP_STATS_EN
    ,
    output logic [CNT_W-1:0]              stat_zero_cnt,
    output logic [CNT_W-1:0]              stat_stall_cnt
`endif
);
    localparam int BEAT_W       = BEAT_BYTES * 8;
    localparam int TOKEN_W      = RUN_W + DATA_W;
    localparam int EL_PER_BEAT  = BEAT_W / DATA_W;
    localparam int TOK_PER_BEAT = BEAT_W / TOKEN_W;
    localparam int IDX_W        = (EL_PER_BEAT > 1) ? $clog2(EL_PER_BEAT) : 1;
    localparam int TIDX_W       = (TOK_PER_BEAT > 1) ? $clog2(TOK_PER_BEAT) : 1;
    localparam int SLOT_W       = (PKT_ELEMS > 1) ? $clog2(PKT_ELEMS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACK, S_UNPACK, S_OUTPUT, S_DONE} state_t;

    state_t                                state, state_next;
    logic [EL_PER_BEAT-1:0][DATA_W-1:0]    beat;
    logic [TOK_PER_BEAT-1:0][TOKEN_W-1:0]  toks;
    logic [PKT_ELEMS-1:0][DATA_W-1:0]      pkt;
    logic                                  mode;
    logic [CNT_W-1:0]                      remaining, rem_dec;
    logic [IDX_W-1:0]                      idx;
    logic [SLOT_W-1:0]                     slot;
    logic [RUN_W-1:0]                      run_cnt, cur_run;
    logic                                  run_active;
    logic                                  beat_empty;
    logic [TOKEN_W-1:0]                    tok;
    logic [DATA_W-1:0]                     elem;
    logic                                  emit_zero, advance, last_in_beat, pkt_full, accept;

    assign toks      = beat;
    assign tok       = toks[idx[TIDX_W-1:0]];
    // A pending run keeps counting down across cycles; otherwise the run comes from the token.
    assign cur_run   = run_active ? run_cnt : tok[TOKEN_W-1:DATA_W];
    assign emit_zero = mode && (cur_run != '0);
    assign advance   = !mode || !emit_zero;
    assign elem      = !mode ? beat[idx] : (emit_zero ? '0 : tok[DATA_W-1:0]);
    assign last_in_beat = !mode ? (idx == IDX_W'(EL_PER_BEAT - 1))
                                : (!emit_zero && idx == IDX_W'(TOK_PER_BEAT - 1));
    assign rem_dec   = remaining - 1'b1;
    assign pkt_full  = (slot == SLOT_W'(PKT_ELEMS - 1));
    assign accept    = pkt_valid && pkt_ready;

    assign mem_req     = (state == S_FETCH) && (remaining != '0);
    assign mem_ack     = (state == S_ACK);
    assign pkt_valid   = (state == S_OUTPUT);
    assign pkt_last    = (state == S_OUTPUT) && (remaining == '0);
    assign pkt_data    = pkt;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (remaining == '0)     state_next = S_DONE;
                else if (mem_data_valid) state_next = S_ACK;
            end
            S_ACK:    state_next = S_UNPACK;
            S_UNPACK: begin
                // A full packet must drain before refetching, even if the beat is also spent.
                if (rem_dec == '0 || pkt_full) state_next = S_OUTPUT;
                else if (last_in_beat)         state_next = S_FETCH;
            end
            S_OUTPUT: begin
                if (accept) begin
                    if (remaining == '0) state_next = S_DONE;
                    else if (beat_empty) state_next = S_FETCH;
                    else                 state_next = S_UNPACK;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            beat        <= '0;
            pkt         <= '0;
            mode        <= 1'b0;
            remaining   <= '0;
            idx         <= '0;
            slot        <= '0;
            run_cnt     <= '0;
            run_active  <= 1'b0;
            beat_empty  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: if (start) begin
                    mode        <= rle_mode;
                    remaining   <= total_elems;
                    err_overrun <= 1'b0;
                    pkt         <= '0;
                    slot        <= '0;
                    run_active  <= 1'b0;
                    beat_empty  <= 1'b0;
                end
                S_FETCH: if (state_next == S_ACK) begin
                    beat       <= mem_data;
                    idx        <= '0;
                    run_active <= 1'b0;
                end
                S_UNPACK: begin
                    pkt[slot]  <= elem;
                    slot       <= slot + 1'b1;
                    remaining  <= rem_dec;
                    beat_empty <= last_in_beat;
                    if (advance) idx <= idx + 1'b1;
                    if (emit_zero) begin
                        run_cnt    <= cur_run - 1'b1;
                        run_active <= 1'b1;
                        if (CNT_W'(cur_run) > remaining) err_overrun <= 1'b1;
                    end else begin
                        run_active <= 1'b0;
                    end
                end
                S_OUTPUT: if (accept) begin
                    pkt  <= '0;
                    slot <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef DECOMP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_zero_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stat_zero_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (state == S_UNPACK && emit_zero && stat_zero_cnt != '1)
                stat_zero_cnt <= stat_zero_cnt + 1'b1;
            if (pkt_valid && !pkt_ready && stat_stall_cnt != '1)
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rle_decompressor.sv
// Directed bench for rle_decompressor: RAW/RLE layers, overrun, stalls, empty layer, reset and start edge cases.
module tb_rle_decompressor;
    logic        clk = 1'b0;
    logic        rst, start, rle_mode, mem_data_valid, pkt_ready;
    logic [19:0] total_elems;
    logic [63:0] mem_data;
    logic        mem_req, mem_ack, pkt_valid, pkt_last, busy, done, err_overrun;
    logic [31:0] pkt_data;
`ifdef DECOMP_STATS_EN
    logic [19:0] stat_zero_cnt, stat_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ack_seen = 0;
    int pkt_cyc = 0;
    int c1, a0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_ack) ack_seen++;

    rle_decompressor dut (
        .clk(clk), .rst(rst), .start(start), .rle_mode(rle_mode), .total_elems(total_elems),
        .mem_req(mem_req), .mem_data(mem_data), .mem_data_valid(mem_data_valid), .mem_ack(mem_ack),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_last(pkt_last),
        .busy(busy), .done(done), .err_overrun(err_overrun)
`ifdef DECOMP_STATS_EN
        , .stat_zero_cnt(stat_zero_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_layer(input logic m, input logic [19:0] n);
        rle_mode = m; total_elems = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic serve_beat(input logic [63:0] d, input int dly, input string tag);
        int t = 0;
        while (!mem_req && t < 60) begin tick(); t++; end
        chk({tag, "_req"}, mem_req, 1);
        repeat (dly) begin tick(); chk({tag, "_req_hold"}, mem_req, 1); end
        mem_data = d; mem_data_valid = 1'b1;
        tick();
        chk({tag, "_ack"}, mem_ack, 1);
        chk({tag, "_req_drop"}, mem_req, 0);
        mem_data_valid = 1'b0; mem_data = '0;
        tick();
        chk({tag, "_ack_pulse"}, mem_ack, 0);
    endtask

    task automatic get_pkt(input logic [31:0] ed, input logic el, input int stall, input string tag);
        int t = 0;
        while (!pkt_valid && t < 60) begin tick(); t++; end
        pkt_cyc = cyc;
        chk({tag, "_valid"}, pkt_valid, 1);
        chk({tag, "_data"}, pkt_data, ed);
        chk({tag, "_last"}, pkt_last, el);
        if (stall > 0) begin
            pkt_ready = 1'b0;
            repeat (stall) begin
                tick();
                chk({tag, "_stall_valid"}, pkt_valid, 1);
                chk({tag, "_stall_data"}, pkt_data, ed);
            end
            pkt_ready = 1'b1;
        end
        tick();
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 60) begin tick(); t++; end
        chk({tag, "_done"}, done, 1);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rle_mode = 1'b0; total_elems = '0;
        mem_data = '0; mem_data_valid = 1'b0; pkt_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {mem_req, mem_ack, pkt_valid, pkt_last, done, err_overrun}, 0);
        chk("rst_pkt_data", pkt_data, 0);

        // RAW, one beat, two packets
        a0 = ack_seen;
        start_layer(1'b0, 20'd8);
        serve_beat(64'h0807060504030201, 0, "raw8");
        get_pkt(32'h04030201, 1'b0, 0, "raw8_p0");
        c1 = pkt_cyc;
        get_pkt(32'h08070605, 1'b1, 0, "raw8_p1");
        chk("raw8_pkt_period", pkt_cyc - c1, 5);
        wait_done("raw8");
        chk("raw8_acks", ack_seen - a0, 1);
        chk("raw8_err", err_overrun, 0);

        // RLE: {2,AA},{0,BB},{1,CC} -> 0,0,AA,BB | 0,CC,pad,pad
        start_layer(1'b1, 20'd6);
        serve_beat(64'h0000_01CC_00BB_02AA, 0, "rle6");
        get_pkt(32'hBBAA0000, 1'b0, 0, "rle6_p0");
        get_pkt(32'h0000CC00, 1'b1, 0, "rle6_p1");
        wait_done("rle6");
        chk("rle6_err", err_overrun, 0);
`ifdef DECOMP_STATS_EN
        chk("rle6_zero_cnt", stat_zero_cnt, 3);
`endif

        // RLE overrun: run 5 with only 3 elements left
        start_layer(1'b1, 20'd3);
        serve_beat(64'h0000_0000_0000_0511, 0, "rle3");
        get_pkt(32'h00000000, 1'b1, 0, "rle3_p0");
        wait_done("rle3");
        chk("rle3_err", err_overrun, 1);

        // Stall for 10 cycles, plus a start pulse while busy that must be ignored
        a0 = ack_seen;
        start_layer(1'b0, 20'd8);
        chk("stall_err_cleared", err_overrun, 0);
        serve_beat(64'h0807060504030201, 0, "stall");
        rle_mode = 1'b1; total_elems = 20'd3; start = 1'b1;
        tick();
        start = 1'b0;
        get_pkt(32'h04030201, 1'b0, 10, "stall_p0");
        get_pkt(32'h08070605, 1'b1, 0, "stall_p1");
        wait_done("stall");
        chk("stall_acks", ack_seen - a0, 1);
`ifdef DECOMP_STATS_EN
        chk("stall_cnt", stat_stall_cnt, 10);
`endif

        // Empty layer: done two cycles after start, never a request
        start_layer(1'b0, 20'd0);
        chk("zero_busy", busy, 1);
        chk("zero_req0", mem_req, 0);
        chk("zero_done_early", done, 0);
        tick();
        chk("zero_req1", mem_req, 0);
        chk("zero_done", done, 1);
        tick();
        chk("zero_idle", {busy, done}, 0);

        // Two beats with a delayed memory response
        a0 = ack_seen;
        start_layer(1'b0, 20'd16);
        serve_beat(64'h0807060504030201, 5, "x16_b0");
        get_pkt(32'h04030201, 1'b0, 0, "x16_p0");
        get_pkt(32'h08070605, 1'b0, 0, "x16_p1");
        serve_beat(64'h100F0E0D0C0B0A09, 0, "x16_b1");
        get_pkt(32'h0C0B0A09, 1'b0, 0, "x16_p2");
        get_pkt(32'h100F0E0D, 1'b1, 0, "x16_p3");
        wait_done("x16");
        chk("x16_acks", ack_seen - a0, 2);

        // Reset in the middle of unpacking
        start_layer(1'b0, 20'd8);
        serve_beat(64'h0807060504030201, 0, "mrst");
        tick();
        chk("mrst_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_outs", {mem_req, mem_ack, pkt_valid, pkt_last, done, err_overrun}, 0);
        chk("mrst_pkt_data", pkt_data, 0);

        // Recovery after reset: short RAW layer
        start_layer(1'b0, 20'd3);
        serve_beat(64'h0807060504030201, 0, "post");
        get_pkt(32'h00030201, 1'b1, 0, "post_p0");
        wait_done("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
